// File: rtl/request_encoder16to4.sv
// Sequential 16-to-4 request encoder: sticky pending register, one grant at a
// time with a Valid/Ack handshake, rotating or fixed priority.
module request_encoder16to4 #(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        En,
    input  logic [15:0] w,
    input  logic        Ack,
    output logic [3:0]  y,
    output logic        Valid,
    output logic        Multi
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pend_q, pend_d;
    logic [3:0]  y_q, y_d;
    logic [3:0]  ptr_q, ptr_d;
    logic        multi_q, multi_d;

    logic [15:0] req;
    logic [15:0] rest;
    logic [3:0]  base;
    logic [3:0]  idx;
    logic [3:0]  sel;
    logic        found;
    logic        take;

    // Selection sees the pointer already advanced past an acked grant, so a
    // back-to-back grant rotates correctly in the same cycle.
    always_comb begin
        req   = pend_q | (En ? w : 16'h0000);
        take  = (state_q == IDLE) || Ack;
        ptr_d = ptr_q;
        if (state_q == GRANT && Ack)
            ptr_d = y_q + 4'd1;
        base  = ROUND_ROBIN ? ptr_d : 4'd0;
        sel   = base;
        idx   = base;
        found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            idx = base + 4'(i);
            if (!found && req[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        rest = req & ~(16'd1 << sel);
    end

    always_comb begin
        state_d = state_q;
        pend_d  = req;
        y_d     = y_q;
        multi_d = multi_q;
        case (state_q)
            IDLE, GRANT: begin
                if (take) begin
                    if (found) begin
                        state_d = GRANT;
                        y_d     = sel;
                        pend_d  = rest;
                        multi_d = |rest;
                    end else begin
                        state_d = IDLE;
                        pend_d  = 16'h0000;
                        multi_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= IDLE;
            pend_q  <= 16'h0000;
            y_q     <= 4'd0;
            ptr_q   <= 4'd0;
            multi_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            y_q     <= y_d;
            ptr_q   <= ptr_d;
            multi_q <= multi_d;
        end
    end

    assign y     = y_q;
    assign Valid = (state_q == GRANT);
    assign Multi = multi_q;

endmodule

// File: tb/tb_request_encoder16to4.sv
// Bench for request_encoder16to4: directed plan steps then random traffic,
// both priority modes checked against a behavioural arbiter model.
module tb_request_encoder16to4;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic        En = 1'b0;
    logic [15:0] w = 16'h0000;
    logic        Ack = 1'b0;
    logic [3:0]  y_rr, y_fx;
    logic        v_rr, v_fx, m_rr, m_fx;

    int passed = 0;
    int total  = 0;

    // model state, index 0 = rotating priority, 1 = fixed priority
    bit [15:0] mp[2];
    int        mptr[2];
    bit        mv[2];
    int        my[2];
    bit        mm[2];

    request_encoder16to4 #(.ROUND_ROBIN(1'b1)) dut_rr (
        .Clock(Clock), .Resetn(Resetn), .En(En), .w(w), .Ack(Ack),
        .y(y_rr), .Valid(v_rr), .Multi(m_rr));

    request_encoder16to4 #(.ROUND_ROBIN(1'b0)) dut_fx (
        .Clock(Clock), .Resetn(Resetn), .En(En), .w(w), .Ack(Ack),
        .y(y_fx), .Valid(v_fx), .Multi(m_fx));

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mp[m] = '0; mptr[m] = 0; mv[m] = 0; my[m] = 0; mm[m] = 0;
        end
    endtask

    task automatic model_edge(input bit en, input bit [15:0] wv, input bit ack);
        for (int m = 0; m < 2; m++) begin
            bit [15:0] q;
            int pick;
            q = mp[m] | (en ? wv : 16'h0000);
            if (mv[m] && ack) mptr[m] = (my[m] + 1) % 16;
            if (!mv[m] || ack) begin
                pick = -1;
                for (int k = 0; k < 16 && pick < 0; k++) begin
                    int i;
                    i = ((m == 0 ? mptr[m] : 0) + k) % 16;
                    if (q[i]) pick = i;
                end
                if (pick < 0) begin
                    mv[m] = 0; mm[m] = 0; mp[m] = '0;
                end else begin
                    q[pick] = 1'b0;
                    my[m] = pick; mv[m] = 1; mp[m] = q; mm[m] = (q != 0);
                end
            end else begin
                mp[m] = q;
            end
        end
    endtask

    task automatic check_all();
        chk("rr_y", int'(y_rr), my[0]);
        chk("rr_valid", int'(v_rr), int'(mv[0]));
        chk("rr_multi", int'(m_rr), int'(mm[0]));
        chk("fx_y", int'(y_fx), my[1]);
        chk("fx_valid", int'(v_fx), int'(mv[1]));
        chk("fx_multi", int'(m_fx), int'(mm[1]));
    endtask

    task automatic step(input bit en, input bit [15:0] wv, input bit ack);
        En = en; w = wv; Ack = ack;
        @(posedge Clock);
        model_edge(en, wv, ack);
        #1;
        check_all();
    endtask

    // async reset pulse placed between clock edges
    task automatic pulse_reset();
        #1;
        Resetn = 1'b0;
        #1;
        model_reset();
        chk("rst_y", int'(y_rr), 0);
        chk("rst_valid", int'(v_rr), 0);
        chk("rst_multi", int'(m_rr), 0);
        check_all();
        Resetn = 1'b1;
    endtask

    initial begin
        model_reset();
        #2;
        check_all();
        chk("por_valid_fx", int'(v_fx), 0);
        Resetn = 1'b1;

        // single request, held grant, ack to idle
        step(1, 16'h0100, 0);
        chk("t1_y", int'(y_rr), 8);
        chk("t1_valid", int'(v_rr), 1);
        chk("t1_multi", int'(m_rr), 0);
        repeat (5) step(1, 16'h0000, 0);
        chk("t1_hold_y", int'(y_rr), 8);
        step(1, 16'h0000, 1);
        chk("t1_done", int'(v_rr), 0);
        // ptr=9: bits 7 and 9 -> rotating picks 9, fixed picks 7
        step(1, 16'h0280, 0);
        chk("t1_ptr_rr", int'(y_rr), 9);
        chk("t1_ptr_fx", int'(y_fx), 7);
        step(1, 16'h0000, 1);
        step(1, 16'h0000, 1);

        // two requests, zero-bubble back-to-back
        pulse_reset();
        step(1, 16'h8001, 0);
        chk("t2_y0", int'(y_rr), 0);
        chk("t2_m0", int'(m_rr), 1);
        step(1, 16'h0000, 1);
        chk("t2_y15", int'(y_rr), 15);
        chk("t2_v15", int'(v_rr), 1);
        chk("t2_fx15", int'(y_fx), 15);
        step(1, 16'h0000, 1);
        chk("t2_idle", int'(v_rr), 0);

        // rotation and wrap
        step(1, 16'h8001, 0);
        chk("t3_wrap", int'(y_rr), 0);
        step(1, 16'h0000, 1);
        step(1, 16'h0000, 1);
        step(1, 16'h0001, 0);
        step(1, 16'h0000, 1);
        step(1, 16'h8001, 0);
        chk("t3_rot_rr", int'(y_rr), 15);
        chk("t3_rot_fx", int'(y_fx), 0);
        step(1, 16'h0000, 1);
        step(1, 16'h0000, 1);

        // capture disabled
        repeat (3) step(0, 16'hFFFF, 0);
        chk("t4_en0", int'(v_rr), 0);
        step(1, 16'h0004, 0);
        chk("t4_y", int'(y_rr), 2);
        step(1, 16'h0000, 1);

        // set wins on the acked index
        step(1, 16'h0008, 0);
        step(1, 16'h0028, 0);
        step(1, 16'h0008, 1);
        chk("t5_other", int'(y_rr), 5);
        step(1, 16'h0000, 1);
        chk("t5_again", int'(y_rr), 3);
        step(1, 16'h0000, 1);
        chk("t5_idle", int'(v_rr), 0);

        // reset mid-grant
        step(1, 16'h00F8, 0);
        pulse_reset();
        step(1, 16'h0000, 0);
        chk("t6_nostale", int'(v_rr), 0);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0) pulse_reset();
            step(($urandom_range(0, 3) != 0), 16'($urandom() & $urandom() & $urandom()),
                 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/request_encoder16to4.md
Name: request_encoder16to4

Overview:
- Sequential 16-to-4 request encoder: the inverse of the 4-to-16 select decoder.
- Collects one-hot or multi-hot request lines from up to 16 datapath units into a sticky pending register.
- Grants one request at a time and presents its 4-bit index on y with a Valid/Ack handshake.
- Sits in front of the bus-select decoder so requesting units take turns driving the shared bus.

Parameters:
- ROUND_ROBIN, 1, 1 = rotating priority starting after the last granted index; 0 = fixed priority, lowest index wins.

Ports:
- Clock  input  1  system clock, rising edge.
- Resetn  input  1  asynchronous active-low reset.
- En  input  1  capture enable for w; when 0, w is ignored but pending requests are still served.
- w  input  16  request vector; bit i requests grant for unit i.
- Ack  input  1  consumer accepts the current grant; meaningful only while Valid=1.
- y  output  4  encoded index of the granted request (registered).
- Valid  output  1  y holds a live grant (registered).
- Multi  output  1  other requests remained pending when the current grant was issued (registered).

Behaviour:
- Reset (Resetn=0, async, any time including mid-grant):
  - Pending P=0, y=0, Valid=0, Multi=0, priority pointer ptr=0, state IDLE.
  - Operation resumes on the first Clock edge after Resetn rises.
- Capture:
  - Each edge, P_next = (P with the granted bit cleared, if a grant issues or is acked this edge) OR (En ? w : 0).
  - Set wins: a w bit equal to the index being cleared in the same cycle is re-pended.
  - Levels are sampled, not edges: a request held for k cycles yields one pending bit until granted.
- Selection function, combinational on Q = P | (En ? w : 0):
  - ROUND_ROBIN=1: first set bit scanning ptr, ptr+1, …, 15, 0, …, ptr-1 (mod-16 wrap).
  - ROUND_ROBIN=0: lowest set bit.
- IDLE:
  - If Q≠0, at the edge: y = selected index, Valid=1, clear that bit in P, Multi = (remaining Q≠0); go to GRANT.
  - Latency: a request on w in cycle t (En=1, IDLE) gives Valid=1 in cycle t+1.
  - If Q=0: stay in IDLE, Valid=0, y holds its last value.
- GRANT:
  - y, Valid and Multi are held stable while Ack=0; newly arriving requests only accumulate in P.
  - On Ack=1: ptr = y+1 mod 16 (15 wraps to 0); ptr is unused when ROUND_ROBIN=0.
  - Ack=1 with Q≠0 after the clear: issue the next grant at the same edge, using the updated ptr. Valid stays 1 (zero-bubble back-to-back); y and Multi update.
  - Ack=1 with Q=0: Valid=0 next cycle; go to IDLE.
- Ack while Valid=0 is ignored.
- The index being granted is never simultaneously pending unless re-requested (set wins).
- All outputs are registers; no combinational path from w or Ack to y, Valid or Multi.

Test Plan:
1. Reset, ROUND_ROBIN=1, En=1, w=16'h0100 for one cycle -> next cycle y=8, Valid=1, Multi=0; hold Ack=0 for 5 cycles -> y=8, Valid=1 stable; Ack=1 -> Valid=0 next cycle, ptr=9.
2. Reset, w=16'h8001 for one cycle -> y=0, Multi=1; Ack -> y=15, Valid stays 1, Multi=0; Ack -> Valid=0. With ROUND_ROBIN=0: same two grants in order 0 then 15.
3. Rotation and wrap: after granting 15 (ptr=0), present w=16'h8001 again -> y=0 first. After granting 0 (ptr=1), w=16'h8001 -> y=15 first.
4. En=0 with w=16'hFFFF for 3 cycles -> Valid stays 0. Then En=1, w=16'h0004 for one cycle -> y=2 next cycle.
5. Set-wins: in GRANT with y=3 and w bit 3 held high through the Ack cycle -> after the grants of any other pending indices, y=3 is granted again.
6. Reset mid-operation: Valid=1, P=16'h00F0; pulse Resetn low between edges -> y=0, Valid=0, Multi=0 immediately, no stale grant after release.
